// File: rtl/dm_cache_pkg.sv
// Shared constants for the direct-mapped cache: address field layout,
// line geometry and the controller state encoding.
package dm_cache_pkg;

   localparam int CACHE_ADDR_W  = 32;
   localparam int CACHE_DATA_W  = 32;
   localparam int CACHE_INDEX_W = 6;
   localparam int CACHE_WORDS   = 4;

   localparam int WORD_LSB  = 2;
   localparam int WORD_W    = 2;
   localparam int INDEX_LSB = 4;
   localparam int TAG_LSB   = 10;
   localparam int TAG_W     = 22;
   localparam int LINES     = 1 << CACHE_INDEX_W;
   localparam int LINE_W    = CACHE_WORDS * CACHE_DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      GAP  = 2'd3
   } state_t;

   // Word address of one word inside a line, as seen by the memory interface.
   function automatic logic [CACHE_ADDR_W-1:0] refill_addr(
      input logic [TAG_W-1:0]         tag,
      input logic [CACHE_INDEX_W-1:0] index,
      input logic [WORD_W-1:0]        word
   );
      return {2'b00, tag, index, word};
   endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Valid/tag/data storage for the cache, all in flops, with a combinational
// read port, a single-word write port, a line-complete port and flush-all.
module dm_cache_array
   import dm_cache_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     inval_en,
   input  logic [CACHE_INDEX_W-1:0] inval_index,
   input  logic                     word_we,
   input  logic                     fill_done,
   input  logic [CACHE_INDEX_W-1:0] wr_index,
   input  logic [WORD_W-1:0]        wr_word,
   input  logic [CACHE_DATA_W-1:0]  wr_data,
   input  logic [TAG_W-1:0]         fill_tag,
   input  logic [CACHE_INDEX_W-1:0] rd_index,
   output logic                     rd_valid,
   output logic [TAG_W-1:0]         rd_tag,
   output logic [LINE_W-1:0]        rd_line
);

   logic [LINES-1:0]        valid_q;
   logic [TAG_W-1:0]        tag_q  [LINES];
   logic [CACHE_DATA_W-1:0] data_q [LINES][CACHE_WORDS];

   // A line only becomes valid once its last word has landed, so an aborted
   // refill never leaves a partially filled line visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         if (inval_en)  valid_q[inval_index] <= 1'b0;
         if (fill_done) valid_q[wr_index]    <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (word_we)   data_q[wr_index][wr_word] <= wr_data;
      if (fill_done) tag_q[wr_index]           <= fill_tag;
   end

   always_comb begin
      rd_valid = valid_q[rd_index];
      rd_tag   = tag_q[rd_index];
      rd_line  = {data_q[rd_index][3], data_q[rd_index][2],
                  data_q[rd_index][1], data_q[rd_index][0]};
   end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache: controller FSM
// and memory request datapath around the dm_cache_array storage.
module dm_cache
   import dm_cache_pkg::*;
#(
   parameter int ADDR_W         = CACHE_ADDR_W,
   parameter int DATA_W         = CACHE_DATA_W,
   parameter int INDEX_W        = CACHE_INDEX_W,
   parameter int WORDS_PER_LINE = CACHE_WORDS
)(
   input  logic              iCLK,
   input  logic              iRST,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_flush,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_MemRead,
   output logic              mem_MemWrite,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

   state_t               state;
   logic [WORD_W-1:0]    counter;
   logic                 is_write;
   logic                 write_hit;
   logic                 retire;
   logic [TAG_W-1:0]     req_tag;
   logic [INDEX_W-1:0]   req_index;
   logic [WORD_W-1:0]    req_word;

   logic [TAG_W-1:0]     cpu_tag;
   logic [INDEX_W-1:0]   cpu_index;
   logic [WORD_W-1:0]    cpu_word;
   logic                 rd_valid;
   logic [TAG_W-1:0]     rd_tag;
   logic [LINE_W-1:0]    rd_line;
   logic                 hit;
   logic                 idle_free;
   logic                 start_write;
   logic                 start_miss;
   logic                 word_we;
   logic                 fill_done;
   logic [WORD_W-1:0]    wr_word;
   logic [DATA_W-1:0]    wr_data;
   logic                 unused_addr_bits;

   assign cpu_tag          = cpu_addr[TAG_LSB +: TAG_W];
   assign cpu_index        = cpu_addr[INDEX_LSB +: INDEX_W];
   assign cpu_word         = cpu_addr[WORD_LSB +: WORD_W];
   assign unused_addr_bits = ^cpu_addr[1:0];

   assign hit         = rd_valid && (rd_tag == cpu_tag);
   assign idle_free   = (state == IDLE) && !retire;
   assign start_write = idle_free && cpu_write;
   assign start_miss  = idle_free && !cpu_write && cpu_read && !hit;

   assign word_we   = ((state == WAIT) && mem_ready && !is_write) ||
                      ((state == GAP) && is_write && write_hit);
   assign fill_done = (state == GAP) && !is_write && (counter == LAST_WORD);
   assign wr_word   = is_write ? req_word : counter;
   assign wr_data   = is_write ? mem_wdata : mem_rdata;

   dm_cache_array u_array (
      .clk         (iCLK),
      .rst         (iRST),
      .flush       (cpu_flush && (state == IDLE)),
      .inval_en    (start_miss),
      .inval_index (cpu_index),
      .word_we     (word_we),
      .fill_done   (fill_done),
      .wr_index    (req_index),
      .wr_word     (wr_word),
      .wr_data     (wr_data),
      .fill_tag    (req_tag),
      .rd_index    (cpu_index),
      .rd_valid    (rd_valid),
      .rd_tag      (rd_tag),
      .rd_line     (rd_line)
   );

   // The retire cycle lets a finished store (or the refilled read) complete
   // without the still-held request immediately starting a new operation.
   always_comb begin
      cpu_stall = 1'b1;
      cpu_rdata = '0;
      if (state == IDLE) begin
         if (retire)         cpu_stall = 1'b0;
         else if (cpu_write) cpu_stall = 1'b1;
         else if (cpu_read)  cpu_stall = !hit;
         else                cpu_stall = 1'b0;
         if (idle_free && cpu_read && !cpu_write && hit)
            cpu_rdata = rd_line[cpu_word*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state        <= IDLE;
         counter      <= '0;
         is_write     <= 1'b0;
         write_hit    <= 1'b0;
         retire       <= 1'b0;
         req_tag      <= '0;
         req_index    <= '0;
         req_word     <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_MemRead  <= 1'b0;
         mem_MemWrite <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               retire <= 1'b0;
               if (start_write) begin
                  mem_addr     <= {2'b00, cpu_addr[ADDR_W-1:2]};
                  mem_wdata    <= cpu_wdata;
                  is_write     <= 1'b1;
                  write_hit    <= hit;
                  req_index    <= cpu_index;
                  req_word     <= cpu_word;
                  mem_MemWrite <= 1'b1;
                  state        <= REQ;
               end else if (start_miss) begin
                  counter     <= '0;
                  is_write    <= 1'b0;
                  req_tag     <= cpu_tag;
                  req_index   <= cpu_index;
                  mem_addr    <= refill_addr(cpu_tag, cpu_index, '0);
                  mem_MemRead <= 1'b1;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (!mem_ready) state <= WAIT;
            end
            WAIT: begin
               if (mem_ready) begin
                  mem_MemRead  <= 1'b0;
                  mem_MemWrite <= 1'b0;
                  state        <= GAP;
               end
            end
            GAP: begin
               if (is_write) begin
                  retire <= 1'b1;
                  state  <= IDLE;
               end else if (counter != LAST_WORD) begin
                  counter     <= counter + 2'd1;
                  mem_addr    <= refill_addr(req_tag, req_index, counter + 2'd1);
                  mem_MemRead <= 1'b1;
                  state       <= REQ;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_cache.sv
// Scoreboard bench for dm_cache: stimulus queues expected memory transactions
// and load data; a memory model and a load monitor pop and compare them.
module tb_dm_cache;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } mem_txn_t;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic [31:0] cpu_addr;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_wdata;
   logic        cpu_flush;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic [31:0] mem_addr;
   logic        mem_MemRead;
   logic        mem_MemWrite;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   mem_txn_t    exp_mem[$];
   logic [31:0] exp_rd[$];
   logic [31:0] fill_base;
   int          n_checks = 0;
   int          n_fail   = 0;

   dm_cache dut (
      .iCLK         (iCLK),
      .iRST         (iRST),
      .cpu_addr     (cpu_addr),
      .cpu_read     (cpu_read),
      .cpu_write    (cpu_write),
      .cpu_wdata    (cpu_wdata),
      .cpu_flush    (cpu_flush),
      .cpu_rdata    (cpu_rdata),
      .cpu_stall    (cpu_stall),
      .mem_addr     (mem_addr),
      .mem_MemRead  (mem_MemRead),
      .mem_MemWrite (mem_MemWrite),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
   );

   always #5 iCLK = ~iCLK;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic void push_mem(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      mem_txn_t t;
      t.wr   = wr;
      t.addr = addr;
      t.data = data;
      exp_mem.push_back(t);
   endfunction

   function automatic void push_fill(input logic [31:0] line_base);
      for (int i = 0; i < 4; i++) push_mem(1'b0, line_base + 32'(i), 32'h0);
   endfunction

   // Memory model: drops ready to accept, returns data two cycles later,
   // then waits for the request to fall before looking for the next one.
   initial begin
      mem_txn_t t;
      int       n;
      mem_ready = 1'b1;
      mem_rdata = '0;
      forever begin
         @(negedge iCLK);
         if (mem_MemRead || mem_MemWrite) begin
            n_checks++;
            if (exp_mem.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL mem_unexpected: got addr %h wr %0d, expected no request",
                        mem_addr, mem_MemWrite);
            end else begin
               t = exp_mem.pop_front();
               check_output("mem_kind", {31'b0, mem_MemWrite}, {31'b0, t.wr});
               check_output("mem_addr", mem_addr, t.addr);
               if (t.wr) check_output("mem_wdata", mem_wdata, t.data);
            end
            mem_ready = 1'b0;
            @(negedge iCLK);
            @(negedge iCLK);
            mem_rdata = fill_base + {30'b0, mem_addr[1:0]};
            mem_ready = 1'b1;
            n = 0;
            while ((mem_MemRead || mem_MemWrite) && n < 20) begin
               @(negedge iCLK);
               n++;
            end
            if (n >= 20) begin
               n_fail++;
               $display("[TB] FAIL mem_req_drop: got request held, expected release");
            end
         end
      end
   end

   // Load monitor: every completed load must match the next queued value.
   always @(negedge iCLK) begin
      if (!iRST && cpu_read && !cpu_stall) begin
         if (exp_rd.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL rd_unexpected: got %h, expected no load", cpu_rdata);
         end else begin
            check_output("cpu_rdata", cpu_rdata, exp_rd.pop_front());
         end
      end
   end

   task automatic wait_unstall(input string name);
      int n = 0;
      while (cpu_stall && n < 300) begin
         @(negedge iCLK);
         n++;
      end
      if (n >= 300) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL %s_timeout: got stall after %0d cycles, expected release", name, n);
      end
   endtask

   // op: 0 = load, 1 = store. exp_hit checks the load completes with no stall.
   task automatic apply_stimulus(input bit op, input logic [31:0] addr,
                                 input logic [31:0] data, input bit exp_hit);
      cpu_addr = addr;
      if (op) begin
         push_mem(1'b1, addr >> 2, data);
         cpu_wdata = data;
         cpu_write = 1'b1;
      end else begin
         exp_rd.push_back(data);
         cpu_read = 1'b1;
      end
      @(negedge iCLK);
      if (exp_hit) check_output("hit_stall", {31'b0, cpu_stall}, 32'h0);
      wait_unstall(op ? "write" : "read");
      @(posedge iCLK);
      #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      iRST      = 1'b1;
      cpu_addr  = '0;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      cpu_wdata = '0;
      cpu_flush = 1'b0;
      fill_base = 32'hA0;
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      check_output("rst_memread",  {31'b0, mem_MemRead},  32'h0);
      check_output("rst_memwrite", {31'b0, mem_MemWrite}, 32'h0);
      check_output("rst_mem_addr", mem_addr,  32'h0);
      check_output("rst_mem_wdata", mem_wdata, 32'h0);
      check_output("rst_stall",    {31'b0, cpu_stall}, 32'h0);
      check_output("rst_rdata",    cpu_rdata, 32'h0);
      @(posedge iCLK);
      #1 iRST = 1'b0;
      @(posedge iCLK);
      #1;

      $display("[TB] read miss fill and hit");
      fill_base = 32'hA0;
      push_fill(32'h40);
      apply_stimulus(1'b0, 32'h104, 32'hA1, 1'b0);
      apply_stimulus(1'b0, 32'h108, 32'hA2, 1'b1);

      $display("[TB] write hit");
      apply_stimulus(1'b1, 32'h104, 32'hDEAD_BEEF, 1'b0);
      apply_stimulus(1'b0, 32'h104, 32'hDEAD_BEEF, 1'b1);
      apply_stimulus(1'b0, 32'h10C, 32'hA3, 1'b1);

      $display("[TB] write miss, no allocate");
      apply_stimulus(1'b1, 32'h2000, 32'h1234_5678, 1'b0);
      fill_base = 32'hB0;
      push_fill(32'h800);
      apply_stimulus(1'b0, 32'h2000, 32'hB0, 1'b0);

      $display("[TB] conflict eviction");
      fill_base = 32'hC0;
      push_fill(32'h140);
      apply_stimulus(1'b0, 32'h504, 32'hC1, 1'b0);
      fill_base = 32'hD0;
      push_fill(32'h40);
      apply_stimulus(1'b0, 32'h104, 32'hD1, 1'b0);

      $display("[TB] reset during refill");
      fill_base = 32'hE0;
      push_mem(1'b0, 32'hC0, 32'h0);
      push_mem(1'b0, 32'hC1, 32'h0);
      push_mem(1'b0, 32'hC2, 32'h0);
      cpu_addr = 32'h300;
      cpu_read = 1'b1;
      n = 0;
      while (!(mem_MemRead && mem_addr == 32'hC2) && n < 300) begin
         @(negedge iCLK);
         n++;
      end
      if (n >= 300) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL refill_word2_timeout: got no request, expected word address c2");
      end
      @(posedge iCLK);
      #1;
      iRST     = 1'b1;
      cpu_read = 1'b0;
      @(posedge iCLK);
      @(negedge iCLK);
      check_output("midrst_memread",  {31'b0, mem_MemRead},  32'h0);
      check_output("midrst_memwrite", {31'b0, mem_MemWrite}, 32'h0);
      @(posedge iCLK);
      #1 iRST = 1'b0;
      repeat (4) @(posedge iCLK);
      #1;
      push_fill(32'hC0);
      apply_stimulus(1'b0, 32'h300, 32'hE0, 1'b0);

      $display("[TB] flush");
      cpu_flush = 1'b1;
      @(negedge iCLK);
      check_output("flush_stall", {31'b0, cpu_stall}, 32'h0);
      @(posedge iCLK);
      #1 cpu_flush = 1'b0;
      fill_base = 32'hF0;
      push_fill(32'hC0);
      apply_stimulus(1'b0, 32'h300, 32'hF0, 1'b0);
      apply_stimulus(1'b0, 32'h308, 32'hF2, 1'b1);

      repeat (10) @(posedge iCLK);
      @(negedge iCLK);
      check_output("mem_queue_left", 32'(exp_mem.size()), 32'h0);
      check_output("rd_queue_left",  32'(exp_rd.size()),  32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
